clock_set_controller: RTL and testbench
=======================================

// Module: clock_set_controller
// PURPOSE
//  Front-panel time-set sequencer for the digital clock. It turns two raw push-buttons
//  (hours, minutes) into the basic_clock mode/fast-set controls, with hold-to-accelerate.
//  It also drives per-field blink enables for the display path.
//  Sits between the chip inputs and basic_clock/clock_to_7seg in clock_wrapper.
// PARAMETERS
//  DEBOUNCE_CYCLES    500_000      consecutive stable cycles before debounced level changes
//  HOLD_FAST_CYCLES   100_000_000  cycles a set button is held before o_fast_set asserts
//  BLINK_HALF_CYCLES  12_500_000   half-period of blink toggle while in a set state
// PORTS
//  i_clk            in   1  system clock (~50MHz)
//  i_reset          in   1  reset, asynchronous, active-high
//  i_en             in   1  enable; low freezes all counters, FSM and outputs
//  i_btn_hours      in   1  raw hours button, active-high, asynchronous to i_clk
//  i_btn_minutes    in   1  raw minutes button, active-high, asynchronous to i_clk
//  o_mode           out  2  00 run, 01 set minutes, 10 set hours (11 never driven)
//  o_fast_set       out  1  1 = fast set rate, 0 = slow set rate
//  o_blank_hours    out  1  1 = blank hours digits (blink phase)
//  o_blank_minutes  out  1  1 = blank minutes digits (blink phase)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM RUN, synchronisers/debounced levels/counters 0. Async assert, sync release.
//  - Input path, per button:
//    - 2-flop synchroniser.
//    - Debounce counter counts while the synced level != the debounced level, and clears when they are equal.
//    - At count == DEBOUNCE_CYCLES-1 the debounced level takes the synced value and the counter clears.
//    - Glitches shorter than DEBOUNCE_CYCLES never propagate.
//  - Press event = debounced rising edge (registered compare, 1-cycle pulse).
//  - Latency: raw press -> o_mode change = DEBOUNCE_CYCLES+3 cycles.
//  - FSM states: RUN, HRS_SLOW, HRS_FAST, MIN_SLOW, MIN_FAST.
//    - RUN -> HRS_SLOW on hours press event. RUN -> MIN_SLOW on minutes press event.
//    - Both events in the same cycle: hours wins.
//    - x_SLOW -> x_FAST when the hold counter reaches HOLD_FAST_CYCLES-1. The hold counter clears on entry to x_SLOW.
//    - Any set state -> RUN when its own debounced button is low. Release takes priority over the fast transition in the same cycle.
//    - In a set state the other button is ignored.
//    - After returning to RUN, a still-held other button does NOT enter set; it must be released and re-pressed (edge-triggered entry).
//  - Outputs (registered from next state):
//    - o_mode: RUN = 00; HRS_* = 10; MIN_* = 01.
//    - o_fast_set = 1 only in x_FAST.
//  - Blink:
//    - Counter and phase clear on entering any set state, with phase = 0 (digits visible).
//    - Phase toggles every BLINK_HALF_CYCLES cycles while in a set state.
//    - o_blank_hours = phase & HRS_*; o_blank_minutes = phase & MIN_*. Both are 0 in RUN.
//  - Counters saturate and never wrap: hold counter stops at terminal; blink counter reloads to 0 on toggle.
//  - i_en low:
//    - Synchronisers keep sampling; debounce, hold and blink counters, the FSM and all outputs hold their values.
//    - No events are lost or generated: edge detection compares debounced levels only when enabled.
//  - Reset mid-operation (e.g. in HRS_FAST): outputs go to 0 immediately, without waiting for a clock.
//    - After release, a still-held button requires a full debounce, then a press event.
// STRUCTURE
//  - Shared package clock_ctrl_pkg holds:
//    - MODE_RUN=2'b00, MODE_SET_MIN=2'b01, MODE_SET_HRS=2'b10;
//    - the FSM state encoding (3-bit localparams);
//    - the counter width helper (clog2).
//  - Sub-module button_debounce (synchroniser + debounce counter + rising-edge pulse), instantiated twice.
//    - Ports: i_clk, i_reset, i_en, i_btn, o_level, o_press.
//  - Top level holds the FSM, hold counter, blink counter and output registers.
// TESTING  (DEBOUNCE_CYCLES=4, HOLD_FAST_CYCLES=20, BLINK_HALF_CYCLES=8)
//  1. Hours glitch high 3 cycles -> o_mode stays 00. Hold high -> o_mode=10 exactly 7 cycles after the raw rise.
//  2. Hold hours -> o_fast_set=1 20 cycles after o_mode=10. Release -> o_mode=00, o_fast_set=0 at 7 cycles.
//  3. Both buttons rise same cycle -> o_mode=10. Release hours, keep minutes -> o_mode=00 and stays 00.
//     Release then re-press minutes -> o_mode=01.
//  4. In MIN_SLOW: o_blank_minutes 0 for 8 cycles, then 1 for 8, repeating; o_blank_hours stays 0.
//  5. Assert i_reset asynchronously mid-cycle in HRS_FAST -> all outputs 0 before the next i_clk edge.
//  6. i_en=0 during hold in MIN_SLOW for 50 cycles -> outputs frozen. i_en=1 -> fast after the remaining hold count only.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared mode codes, FSM state encoding and counter sizing helpers for the
// front-panel time-set controller.
package clock_ctrl_pkg;

   localparam logic [1:0] MODE_RUN     = 2'b00;
   localparam logic [1:0] MODE_SET_MIN = 2'b01;
   localparam logic [1:0] MODE_SET_HRS = 2'b10;

   localparam logic [2:0] ST_RUN      = 3'd0;
   localparam logic [2:0] ST_HRS_SLOW = 3'd1;
   localparam logic [2:0] ST_HRS_FAST = 3'd2;
   localparam logic [2:0] ST_MIN_SLOW = 3'd3;
   localparam logic [2:0] ST_MIN_FAST = 3'd4;

   typedef enum logic [2:0] {
      S_RUN      = ST_RUN,
      S_HRS_SLOW = ST_HRS_SLOW,
      S_HRS_FAST = ST_HRS_FAST,
      S_MIN_SLOW = ST_MIN_SLOW,
      S_MIN_FAST = ST_MIN_FAST
   } state_t;

   // Bits needed to hold the values 0 .. n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic logic [1:0] state_mode(input state_t s);
      case (s)
         S_HRS_SLOW, S_HRS_FAST: return MODE_SET_HRS;
         S_MIN_SLOW, S_MIN_FAST: return MODE_SET_MIN;
         default:                return MODE_RUN;
      endcase
   endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button input path: 2-flop synchroniser, stability counter that
// moves the debounced level, and a one-cycle pulse on its rising edge.
module button_debounce
   import clock_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_en,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          prev_q;

   // The synchroniser samples even while disabled so no raw activity is missed.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= i_btn;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         level_d = sync2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
      end else if (i_en) begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         prev_q  <= level_q;
      end
   end

   // prev_q only advances when enabled, so an edge seen while frozen is held, not lost.
   assign o_level = level_q;
   assign o_press = i_en & level_q & ~prev_q;

endmodule

// File: rtl/clock_set_controller.sv
// Time-set sequencer: debounced hours/minutes buttons drive the set-mode FSM,
// the hold-to-accelerate counter and the per-field blink phase.
module clock_set_controller
   import clock_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 500_000,
   parameter int HOLD_FAST_CYCLES  = 100_000_000,
   parameter int BLINK_HALF_CYCLES = 12_500_000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_en,
   input  logic       i_btn_hours,
   input  logic       i_btn_minutes,
   output logic [1:0] o_mode,
   output logic       o_fast_set,
   output logic       o_blank_hours,
   output logic       o_blank_minutes
);

   localparam int            HW         = cnt_width(HOLD_FAST_CYCLES);
   localparam int            BW         = cnt_width(BLINK_HALF_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FAST_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYCLES - 1);
   localparam int            BTN_MIN    = 0;
   localparam int            BTN_HRS    = 1;

   // Reset asserts immediately but is released on a clock edge.
   logic [1:0] rst_sync_q;
   logic       rst_int;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) rst_sync_q <= 2'b11;
      else         rst_sync_q <= {rst_sync_q[0], 1'b0};
   end
   assign rst_int = rst_sync_q[1];

   logic [1:0] btn_raw, btn_level, btn_press;
   assign btn_raw = {i_btn_hours, i_btn_minutes};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_btn
         button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .i_clk   (i_clk),
            .i_reset (rst_int),
            .i_en    (i_en),
            .i_btn   (btn_raw[gi]),
            .o_level (btn_level[gi]),
            .o_press (btn_press[gi])
         );
      end
   endgenerate

   state_t        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [BW-1:0] blink_q, blink_d;
   logic          phase_q, phase_d;
   logic [1:0]    mode_q, mode_d;
   logic          fast_q, fast_d;
   logic          blank_h_q, blank_h_d;
   logic          blank_m_q, blank_m_d;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      blink_d = blink_q;
      phase_d = phase_q;

      // Release is tested before the hold terminal so it wins in the same cycle.
      case (state_q)
         S_RUN: begin
            if (btn_press[BTN_HRS])      state_d = S_HRS_SLOW;
            else if (btn_press[BTN_MIN]) state_d = S_MIN_SLOW;
         end
         S_HRS_SLOW: begin
            if (!btn_level[BTN_HRS])     state_d = S_RUN;
            else if (hold_q == HOLD_LAST) state_d = S_HRS_FAST;
         end
         S_HRS_FAST: begin
            if (!btn_level[BTN_HRS])     state_d = S_RUN;
         end
         S_MIN_SLOW: begin
            if (!btn_level[BTN_MIN])     state_d = S_RUN;
            else if (hold_q == HOLD_LAST) state_d = S_MIN_FAST;
         end
         S_MIN_FAST: begin
            if (!btn_level[BTN_MIN])     state_d = S_RUN;
         end
         default: state_d = S_RUN;
      endcase

      if (state_q == S_RUN || state_d == S_RUN) begin
         hold_d  = '0;
         blink_d = '0;
         phase_d = 1'b0;
      end else begin
         if (hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;
         if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
         end else begin
            blink_d = blink_q + 1'b1;
         end
      end

      mode_d    = state_mode(state_d);
      fast_d    = (state_d == S_HRS_FAST) || (state_d == S_MIN_FAST);
      blank_h_d = phase_d & ((state_d == S_HRS_SLOW) || (state_d == S_HRS_FAST));
      blank_m_d = phase_d & ((state_d == S_MIN_SLOW) || (state_d == S_MIN_FAST));
   end

   always_ff @(posedge i_clk or posedge rst_int) begin
      if (rst_int) begin
         state_q   <= S_RUN;
         hold_q    <= '0;
         blink_q   <= '0;
         phase_q   <= 1'b0;
         mode_q    <= MODE_RUN;
         fast_q    <= 1'b0;
         blank_h_q <= 1'b0;
         blank_m_q <= 1'b0;
      end else if (i_en) begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         blink_q   <= blink_d;
         phase_q   <= phase_d;
         mode_q    <= mode_d;
         fast_q    <= fast_d;
         blank_h_q <= blank_h_d;
         blank_m_q <= blank_m_d;
      end
   end

   assign o_mode          = mode_q;
   assign o_fast_set      = fast_q;
   assign o_blank_hours   = blank_h_q;
   assign o_blank_minutes = blank_m_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench: stimulus pushes cycle-tagged expected outputs into a
// scoreboard queue; a monitor pops and compares them as the cycles arrive.
module tb_clock_set_controller;

   localparam int DB    = 4;
   localparam int HOLD  = 20;
   localparam int BLINK = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b1;
   logic       btn_h = 1'b0;
   logic       btn_m = 1'b0;
   logic [1:0] o_mode;
   logic       o_fast_set, o_blank_hours, o_blank_minutes;
   logic [4:0] dut_out;

   clock_set_controller #(
      .DEBOUNCE_CYCLES   (DB),
      .HOLD_FAST_CYCLES  (HOLD),
      .BLINK_HALF_CYCLES (BLINK)
   ) dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .i_en            (en),
      .i_btn_hours     (btn_h),
      .i_btn_minutes   (btn_m),
      .o_mode          (o_mode),
      .o_fast_set      (o_fast_set),
      .o_blank_hours   (o_blank_hours),
      .o_blank_minutes (o_blank_minutes)
   );

   assign dut_out = {o_mode, o_fast_set, o_blank_hours, o_blank_minutes};

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [4:0] exp;
      logic [4:0] mask;
      string      name;
   } sb_t;

   sb_t  sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   event chk_ev;

   // Expected outputs in a set state, k = enabled cycles since entry.
   function automatic logic [4:0] set_vec(input bit hrs, input int k);
      logic ph;
      logic fast;
      ph   = ((k / BLINK) % 2) == 1;
      fast = (k >= HOLD);
      return hrs ? {2'b10, fast, ph, 1'b0} : {2'b01, fast, 1'b0, ph};
   endfunction

   task automatic push(input int c, input logic [4:0] v, input logic [4:0] m, input string nm);
      sb_t e;
      e.cyc = c; e.exp = v; e.mask = m; e.name = nm;
      sb_q.push_back(e);
   endtask

   task automatic push_run(input int c0, input int c1, input string nm);
      for (int c = c0; c <= c1; c++) push(c, 5'b00000, 5'b11111, nm);
   endtask

   task automatic push_set(input int c0, input int c1, input int e, input bit hrs,
                           input int fz, input int fzlen, input string nm);
      for (int c = c0; c <= c1; c++) begin
         int k;
         k = c - e;
         if (fzlen > 0 && c > fz) k = (c >= fz + fzlen) ? (c - e - fzlen) : (fz - e);
         push(c, set_vec(hrs, k), 5'b11111, nm);
      end
   endtask

   task automatic goto(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d expectations still pending at cyc=%0d, required 0", sb_q.size(), cyc);
         sb_q.delete();
      end
   endtask

   // Monitor: compares every expectation whose cycle has arrived.
   initial begin
      sb_t e;
      forever begin
         @(negedge clk or chk_ev);
         while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n_vec++;
            if (e.cyc < cyc) begin
               n_err++;
               $display("FAIL %s: stale expectation for cyc=%0d at cyc=%0d, required %b", e.name, e.cyc, cyc, e.exp);
            end else if ((dut_out & e.mask) !== (e.exp & e.mask)) begin
               n_err++;
               $display("FAIL %s: cyc=%0d got=%b required=%b mask=%b", e.name, cyc, dut_out, e.exp, e.mask);
            end else begin
               $display("vec %0d %s cyc=%0d out=%b ok", n_vec, e.name, cyc, dut_out);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      #1 rst = 1'b1;
      @(negedge clk);

      // Reset state
      t = cyc;
      push_run(t + 1, t + 3, "reset");
      goto(t + 3);
      rst = 1'b0;
      goto(t + 8);
      drain();

      // 1a: 3-cycle glitch on hours never propagates
      t = cyc;
      btn_h = 1'b1;
      push_run(t + 1, t + 14, "glitch");
      goto(t + 3);
      btn_h = 1'b0;
      goto(t + 14);
      drain();

      // 1b + 2: hold hours -> set at +7, fast 20 later, release -> run at +7
      t = cyc;
      btn_h = 1'b1;
      push_run(t + 1, t + 6, "hrs_latency");
      push_set(t + 7, t + 46, t + 7, 1'b1, 0, 0, "hrs_hold");
      push_run(t + 47, t + 50, "hrs_release");
      goto(t + 40);
      btn_h = 1'b0;
      goto(t + 50);
      drain();

      // 3 + 4: both pressed -> hours; held minutes ignored; re-press minutes
      t = cyc;
      btn_h = 1'b1;
      btn_m = 1'b1;
      push_run(t + 1, t + 6, "both_latency");
      push_set(t + 7, t + 18, t + 7, 1'b1, 0, 0, "both_hrs_wins");
      push_run(t + 19, t + 48, "min_still_held");
      push_set(t + 49, t + 86, t + 49, 1'b0, 0, 0, "min_blink");
      push_run(t + 87, t + 90, "min_release");
      goto(t + 12);
      btn_h = 1'b0;
      goto(t + 32);
      btn_m = 1'b0;
      goto(t + 42);
      btn_m = 1'b1;
      goto(t + 80);
      btn_m = 1'b0;
      goto(t + 90);
      drain();

      // 5: asynchronous reset in HRS_FAST, then held button re-debounces
      t = cyc;
      btn_h = 1'b1;
      push_run(t + 1, t + 6, "pre_fast");
      push_set(t + 7, t + 30, t + 7, 1'b1, 0, 0, "to_fast");
      goto(t + 30);
      @(posedge clk);
      #2 rst = 1'b1;
      push(cyc, 5'b00000, 5'b11111, "async_reset");
      #1 -> chk_ev;
      push_run(t + 32, t + 35, "in_reset");
      goto(t + 35);
      rst = 1'b0;
      push_run(t + 36, t + 41, "post_reset_debounce");
      for (int c = t + 50; c <= t + 55; c++) push(c, 5'b10000, 5'b11000, "post_reset_press");
      push_run(t + 62, t + 65, "post_reset_release");
      goto(t + 55);
      btn_h = 1'b0;
      goto(t + 65);
      drain();

      // 6: i_en low for 50 cycles during MIN_SLOW freezes everything
      t = cyc;
      btn_m = 1'b1;
      push_run(t + 1, t + 6, "en_latency");
      push_set(t + 7, t + 96, t + 7, 1'b0, t + 12, 50, "en_freeze");
      push_run(t + 97, t + 100, "en_release");
      goto(t + 12);
      en = 1'b0;
      goto(t + 62);
      en = 1'b1;
      goto(t + 90);
      btn_m = 1'b0;
      goto(t + 100);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
